ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter for the keyboard port. It is the outbound counterpart of the keyboard receive path. It serialises command bytes into the open-drain PS/2 clock/data pair wired to hps_io `ps2_kbd_*_in`: LED set 0xED, reset 0xFF, typematic 0xF3. It runs in the `clk_sys` domain (14.318 MHz) and hands the lines back to the receiver when idle.

---
 rtl/ps2_host_tx_if.sv | 25 ++
 rtl/ps2_host_tx.sv | 171 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Byte-request handshake between a command source and the PS/2 host transmitter.
// The master offers tx_data with tx_valid; the slave reports tx_ready and one-cycle done/error pulses.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output tx_done,
        output tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: clock inhibit, start, 8 data LSB first, odd parity, stop, device ack.
// Latency: device clock fall -> ps2_data_o in 3 cycles; backpressure: tx_ready low for the whole frame, busy requests dropped.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1432,
    parameter int TIMEOUT_CYCLES = 214770
) (
    input  logic         clk_sys,
    input  logic         reset,
    ps2_host_tx_if.slave tx_if,
    input  logic         ps2_clk_i,
    input  logic         ps2_data_i,
    output logic         ps2_clk_o,
    output logic         ps2_data_o
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_BITS,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        r_state;
    logic [8:0]    r_shift;
    logic [3:0]    r_bit_cnt;
    logic [IW-1:0] r_inh_cnt;
    logic [TW-1:0] r_tout_cnt;
    logic          r_clk_o;
    logic          r_data_o;
    logic          r_ready;
    logic          r_done;
    logic          r_error;

    logic          r_clk_meta;
    logic          r_clk_sync;
    logic          r_clk_prev;
    logic          r_dat_meta;
    logic          r_dat_sync;

    logic          w_fall;
    logic          w_tout_run;
    logic          w_tout_hit;

    // Idle lines are high, so synchroniser reset values of 1 avoid a phantom edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk_i;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2_data_i;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign w_fall     = r_clk_prev & ~r_clk_sync;
    assign w_tout_run = (r_state == S_REQ) || (r_state == S_BITS) ||
                        (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_tout_hit = w_tout_run && (r_tout_cnt == TO_LAST);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_inh_cnt  <= '0;
            r_tout_cnt <= '0;
            r_clk_o    <= 1'b1;
            r_data_o   <= 1'b1;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            // Timeout wins over any line event seen in the same cycle.
            if (w_tout_hit) begin
                r_state    <= S_IDLE;
                r_clk_o    <= 1'b1;
                r_data_o   <= 1'b1;
                r_ready    <= 1'b1;
                r_error    <= 1'b1;
                r_tout_cnt <= '0;
            end else begin
                if (w_tout_run) begin
                    r_tout_cnt <= r_tout_cnt + TW'(1);
                end
                case (r_state)
                    S_IDLE: begin
                        if (tx_if.tx_valid) begin
                            r_shift   <= {~^tx_if.tx_data, tx_if.tx_data};
                            r_inh_cnt <= '0;
                            r_clk_o   <= 1'b0;
                            r_ready   <= 1'b0;
                            r_state   <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (r_inh_cnt == INH_LAST) begin
                            r_clk_o    <= 1'b1;
                            r_data_o   <= 1'b0;
                            r_tout_cnt <= '0;
                            r_state    <= S_REQ;
                        end else begin
                            r_inh_cnt <= r_inh_cnt + IW'(1);
                        end
                    end
                    S_REQ: begin
                        r_bit_cnt <= '0;
                        r_state   <= S_BITS;
                    end
                    S_BITS: begin
                        if (w_fall) begin
                            if (r_bit_cnt == 4'd9) begin
                                r_data_o <= 1'b1;
                                r_state  <= S_ACK;
                            end else begin
                                r_data_o  <= r_shift[0];
                                r_shift   <= {1'b1, r_shift[8:1]};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_ACK: begin
                        if (w_fall) begin
                            if (!r_dat_sync) begin
                                r_state <= S_WAIT_IDLE;
                            end else begin
                                r_error <= 1'b1;
                                r_ready <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (r_clk_sync && r_dat_sync) begin
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_clk_o  <= 1'b1;
                        r_data_o <= 1'b1;
                        r_ready  <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ps2_clk_o      = r_clk_o;
    assign ps2_data_o     = r_data_o;
    assign tx_if.tx_ready = r_ready;
    assign tx_if.tx_done  = r_done;
    assign tx_if.tx_error = r_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: table of byte transfers against a PS/2 device model, plus timeout and async-reset sequences.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TOUT = 3000;
    // Device half period chosen so a whole frame plus ack fits inside the 3000-cycle timeout.
    localparam int HALF = 100;

    logic clk_sys;
    logic reset;
    logic dev_clk;
    logic dev_dat;
    logic ps2_clk_o;
    logic ps2_data_o;
    wire  ps2_clk_line  = ps2_clk_o & dev_clk;
    wire  ps2_data_line = ps2_data_o & dev_dat;

    ps2_host_tx_if tx_if ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .tx_if      (tx_if),
        .ps2_clk_i  (ps2_clk_line),
        .ps2_data_i (ps2_data_line),
        .ps2_clk_o  (ps2_clk_o),
        .ps2_data_o (ps2_data_o)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int low_cnt  = 0;

    always @(negedge clk_sys) begin
        if (tx_if.tx_done)  done_cnt++;
        if (tx_if.tx_error) err_cnt++;
        if (!ps2_clk_o)     low_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       inject;
        logic       exp_par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input string tag);
        @(negedge clk_sys);
        check({tag, "_ready_before"}, tx_if.tx_ready, 1);
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = d;
        @(negedge clk_sys);
        tx_if.tx_valid = 1'b0;
        check({tag, "_ready_after_accept"}, tx_if.tx_ready, 0);
        check({tag, "_clk_low_after_accept"}, ps2_clk_o, 0);
    endtask

    task automatic wait_req(input string tag, output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_sys);
            if (ps2_data_o == 1'b0 && ps2_clk_o == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s_req: no start bit within 200 cycles", tag);
        end
    endtask

    task automatic wait_ready(input string tag);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_sys);
            if (tx_if.tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s_ready_return: tx_ready still 0 after 400 cycles", tag);
        end
        @(negedge clk_sys);
    endtask

    // Device: samples the line on each rising edge; optionally pulls data low across edge 11 as ack.
    task automatic run_device(input logic ack, output logic [10:0] bits);
        bits = '0;
        repeat (20) @(negedge clk_sys);
        bits[0] = ps2_data_line;
        for (int e = 1; e <= 11; e++) begin
            if (e == 11 && ack) begin
                dev_dat = 1'b0;
                repeat (5) @(negedge clk_sys);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk_sys);
            dev_clk = 1'b1;
            if (e <= 10) bits[e] = ps2_data_line;
            repeat (HALF) @(negedge clk_sys);
        end
        dev_dat = 1'b1;
    endtask

    task automatic do_xfer(input vec_t v, input string tag);
        int          l0, d0, e0, l1;
        logic [10:0] bits;
        logic [10:0] exp_frame;
        logic        ok;
        bits = '0;
        l0 = low_cnt;
        d0 = done_cnt;
        e0 = err_cnt;
        send(v.data, tag);
        wait_req(tag, ok);
        if (ok) begin
            fork
                run_device(v.ack, bits);
                begin
                    if (v.inject) begin
                        repeat (600) @(negedge clk_sys);
                        tx_if.tx_valid = 1'b1;
                        tx_if.tx_data  = 8'h55;
                        repeat (300) @(negedge clk_sys);
                        tx_if.tx_valid = 1'b0;
                    end
                end
            join
        end
        exp_frame = {1'b1, v.exp_par, v.data, 1'b0};
        check({tag, "_frame"}, 32'(bits), 32'(exp_frame));
        wait_ready(tag);
        check({tag, "_inhibit_len"}, low_cnt - l0, INH);
        check({tag, "_done_pulses"}, done_cnt - d0, v.exp_done);
        check({tag, "_error_pulses"}, err_cnt - e0, v.exp_err);
        check({tag, "_clk_released"}, ps2_clk_o, 1);
        check({tag, "_data_released"}, ps2_data_o, 1);
        l1 = low_cnt;
        repeat (50) @(negedge clk_sys);
        check({tag, "_no_extra_xfer"}, low_cnt - l1, 0);
        check({tag, "_ready_idle"}, tx_if.tx_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[6];

    initial begin
        int          n;
        int          d0, e0;
        logic        ok;
        vec_t        vf3;

        vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1, 0};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b0, 1, 0};
        vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b1, 0, 1};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1, 0};

        reset          = 1'b1;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;
        dev_clk        = 1'b1;
        dev_dat        = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("rst_clk_o", ps2_clk_o, 1);
        check("rst_data_o", ps2_data_o, 1);
        check("rst_ready", tx_if.tx_ready, 1);
        check("rst_done", tx_if.tx_done, 0);
        check("rst_error", tx_if.tx_error, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk_sys);

        for (int i = 0; i < 6; i++) begin
            do_xfer(vecs[i], $sformatf("vec%0d", i));
        end

        // Device never clocks: error exactly TOUT cycles after the start-bit cycle.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h3C, "tout");
        wait_req("tout", ok);
        n = 0;
        if (ok) begin
            while (n < 4000 && !tx_if.tx_error) begin
                @(negedge clk_sys);
                n++;
            end
        end
        check("tout_latency", n, TOUT);
        @(negedge clk_sys);
        check("tout_data_released", ps2_data_o, 1);
        check("tout_clk_released", ps2_clk_o, 1);
        check("tout_ready", tx_if.tx_ready, 1);
        check("tout_error_pulses", err_cnt - e0, 1);
        check("tout_done_pulses", done_cnt - d0, 0);

        // Asynchronous reset part-way through the data bits.
        send(8'h5A, "arst");
        wait_req("arst", ok);
        repeat (20) @(negedge clk_sys);
        dev_clk = 1'b0;
        repeat (20) @(negedge clk_sys);
        check("arst_bit0_driven", ps2_data_o, 0);
        dev_clk = 1'b1;
        d0 = done_cnt;
        e0 = err_cnt;
        @(posedge clk_sys);
        #3;
        reset = 1'b1;
        #1;
        check("arst_clk_o", ps2_clk_o, 1);
        check("arst_data_o", ps2_data_o, 1);
        check("arst_ready", tx_if.tx_ready, 1);
        #2;
        reset = 1'b0;
        repeat (300) @(negedge clk_sys);
        check("arst_no_done", done_cnt - d0, 0);
        check("arst_no_error", err_cnt - e0, 0);
        check("arst_lines_idle", {ps2_clk_o, ps2_data_o}, 2'b11);

        vf3 = '{8'hF3, 1'b1, 1'b0, 1'b1, 1, 0};
        do_xfer(vf3, "after_rst_f3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
